// File: rtl/uart_rx_packer_if.sv
// Word stream from the packer FIFO to its consumer: valid/ready handshake with a 32-bit payload.
interface uart_rx_packer_if;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/uart_rx_packer.sv
// Packs UART receiver bytes little-endian into 32-bit words and queues them in a small
// first-word-fall-through FIFO; stale partial words are dropped after an idle timeout.
module uart_rx_packer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 40000
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         uart_done,
    input  logic [7:0]                   uart_data,
    input  logic                         flush,
    uart_rx_packer_if.master             word_if,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         partial_drop
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);

    logic              done_q;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       held_q, held_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              pdrop_q, pdrop_d;

    logic              strobe;
    logic              full;
    logic              valid;
    logic              pop;
    logic              push;
    logic              push_ok;
    logic              timeout;

    // done_q resets high so a level already present at reset release is not a new byte.
    assign strobe  = uart_done & ~done_q;
    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign valid   = (count_q != '0);
    assign pop     = valid & word_if.word_ready & ~flush;
    assign push    = strobe & (byte_idx_q == 2'd3) & ~flush;
    assign push_ok = push & (~full | pop);
    assign timeout = (byte_idx_q != 2'd0) & ~strobe & (idle_q == IdleW'(TIMEOUT_CYC - 1));

    always_comb begin
        byte_idx_d = byte_idx_q;
        held_d     = held_q;
        idle_d     = idle_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        pdrop_d    = 1'b0;

        if (flush) begin
            byte_idx_d = 2'd0;
            held_d     = '0;
            idle_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
        end else begin
            if (strobe) begin
                byte_idx_d = byte_idx_q + 2'd1;
                idle_d     = '0;
                unique case (byte_idx_q)
                    2'd0: held_d[7:0]   = uart_data;
                    2'd1: held_d[15:8]  = uart_data;
                    2'd2: held_d[23:16] = uart_data;
                    2'd3: held_d        = '0;
                endcase
            end else if (timeout) begin
                byte_idx_d = 2'd0;
                held_d     = '0;
                idle_d     = '0;
                pdrop_d    = 1'b1;
            end else if (byte_idx_q == 2'd0) begin
                idle_d = '0;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end

            // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
            if (push_ok) begin
                mem_d[wr_ptr_q] = {uart_data, held_q};
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end else if (push) begin
                ovf_d = 1'b1;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end

            if (push_ok && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push_ok) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            done_q     <= 1'b1;
            byte_idx_q <= 2'd0;
            held_q     <= '0;
            idle_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            pdrop_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q     <= uart_done;
            byte_idx_q <= byte_idx_d;
            held_q     <= held_d;
            idle_q     <= idle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            pdrop_q    <= pdrop_d;
            mem_q      <= mem_d;
        end
    end

    assign word_if.word_valid = valid;
    assign word_if.word_data  = mem_q[rd_ptr_q];
    assign fifo_count         = count_q;
    assign overflow           = ovf_q;
    assign partial_drop       = pdrop_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: a queue-based model is compared every cycle,
// and literal word/flag expectations pin each scenario.
module tb_uart_rx_packer;

    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned TIMEOUT_CYC = 300;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       flush;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       partial_drop;

    uart_rx_packer_if wif ();

    uart_rx_packer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_done    (uart_done),
        .uart_data    (uart_data),
        .flush        (flush),
        .word_if      (wif),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .partial_drop (partial_drop)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bytes pending, words queued, sticky flag, idle age of the partial word.
    bit          m_prev_done;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_words[$];
    bit          m_ovf;
    bit          m_pdrop;
    int          m_idle;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        bit          stb;
        logic [31:0] w;
        if (!sys_rst_n) begin
            m_prev_done = 1'b1;
            m_bytes.delete();
            m_words.delete();
            m_ovf   = 1'b0;
            m_pdrop = 1'b0;
            m_idle  = 0;
        end else begin
            stb         = uart_done && !m_prev_done;
            m_prev_done = uart_done;
            m_pdrop     = 1'b0;
            if (flush) begin
                m_bytes.delete();
                m_words.delete();
                m_ovf  = 1'b0;
                m_idle = 0;
            end else begin
                if (m_words.size() > 0 && wif.word_ready) void'(m_words.pop_front());
                if (stb) begin
                    m_bytes.push_back(uart_data);
                    m_idle = 0;
                    if (m_bytes.size() == 4) begin
                        w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                        m_bytes.delete();
                        if (m_words.size() < FIFO_DEPTH) m_words.push_back(w);
                        else m_ovf = 1'b1;
                    end
                end else if (m_bytes.size() > 0) begin
                    m_idle++;
                    if (m_idle == TIMEOUT_CYC) begin
                        m_bytes.delete();
                        m_pdrop = 1'b1;
                        m_idle  = 0;
                    end
                end else begin
                    m_idle = 0;
                end
            end
        end
    end

    logic [31:0] pop_log[$];
    int          vcycles;
    int          pdrop_cnt;

    always @(negedge sys_clk) begin
        chk("word_valid", 32'(wif.word_valid), 32'(m_words.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(m_words.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("partial_drop", 32'(partial_drop), 32'(m_pdrop));
        if (m_words.size() > 0) chk("word_data", wif.word_data, m_words[0]);
        if (wif.word_valid) vcycles++;
        if (partial_drop) pdrop_cnt++;
        if (sys_rst_n && wif.word_valid && wif.word_ready && !flush) pop_log.push_back(wif.word_data);
    end

    function automatic logic [31:0] logged(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_data = b;
        uart_done = 1'b1;
        step(130);
        uart_done = 1'b0;
        step(10);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    initial begin
        sys_rst_n      = 1'b0;
        uart_done      = 1'b0;
        uart_data      = 8'h00;
        flush          = 1'b0;
        wif.word_ready = 1'b0;
        vcycles        = 0;
        pdrop_cnt      = 0;
        step(3);
        chk("rst_valid", 32'(wif.word_valid), 32'd0);
        chk("rst_data", wif.word_data, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_pdrop", 32'(partial_drop), 32'd0);
        sys_rst_n = 1'b1;
        step(2);

        // Single word with a long uart_done level per byte.
        wif.word_ready = 1'b1;
        pop_log.delete();
        vcycles = 0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        step(5);
        chk("w1_valid_cycles", 32'(vcycles), 32'd1);
        chk("w1_nwords", 32'(pop_log.size()), 32'd1);
        chk("w1_word", logged(0), 32'h4433_2211);
        chk("w1_count", 32'(fifo_count), 32'd0);

        // Overfill with consumer stalled, then drain.
        wif.word_ready = 1'b0;
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        step(5);
        chk("ovf_count_hold", 32'(fifo_count), 32'd4);
        pop_log.delete();
        wif.word_ready = 1'b1;
        step(6);
        chk("ovf_nwords", 32'(pop_log.size()), 32'd4);
        chk("ovf_w0", logged(0), 32'h0302_0100);
        chk("ovf_w1", logged(1), 32'h0706_0504);
        chk("ovf_w2", logged(2), 32'h0B0A_0908);
        chk("ovf_w3", logged(3), 32'h0F0E_0D0C);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_flush();
        chk("ovf_flushed", 32'(overflow), 32'd0);

        // Partial word timeout, then a clean word.
        pdrop_cnt = 0;
        send_byte(8'hAA); send_byte(8'hBB);
        step(TIMEOUT_CYC + 5);
        chk("to_pulses", 32'(pdrop_cnt), 32'd1);
        chk("to_count", 32'(fifo_count), 32'd0);
        pop_log.delete();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        step(3);
        chk("to_nwords", 32'(pop_log.size()), 32'd1);
        chk("to_word", logged(0), 32'h0403_0201);

        // Push and pop on the same edge while full.
        wif.word_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        chk("full_count", 32'(fifo_count), 32'd4);
        send_byte(8'h30); send_byte(8'h31); send_byte(8'h32);
        uart_data      = 8'h33;
        uart_done      = 1'b1;
        wif.word_ready = 1'b1;
        step(1);
        wif.word_ready = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        step(129);
        uart_done = 1'b0;
        step(10);
        pop_log.delete();
        wif.word_ready = 1'b1;
        step(6);
        chk("pp_w0", logged(0), 32'h2726_2524);
        chk("pp_w3", logged(3), 32'h3332_3130);

        // Flush coinciding with a fourth-byte strobe.
        wif.word_ready = 1'b0;
        for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i));
        wif.word_ready = 1'b1;
        step(1);
        wif.word_ready = 1'b0;
        chk("fl_count_pre", 32'(fifo_count), 32'd3);
        chk("fl_ovf_pre", 32'(overflow), 32'd1);
        send_byte(8'h60); send_byte(8'h61); send_byte(8'h62);
        uart_data = 8'h63;
        uart_done = 1'b1;
        flush     = 1'b1;
        step(1);
        flush = 1'b0;
        chk("fl_count", 32'(fifo_count), 32'd0);
        chk("fl_valid", 32'(wif.word_valid), 32'd0);
        chk("fl_ovf", 32'(overflow), 32'd0);
        chk("fl_byte_idx", 32'(dut.byte_idx_q), 32'd0);
        step(129);
        uart_done = 1'b0;
        step(10);
        chk("fl_byte_idx_late", 32'(dut.byte_idx_q), 32'd0);

        // Reset mid-word with words queued.
        for (int i = 0; i < 10; i++) send_byte(8'(8'h70 + i));
        chk("rm_count_pre", 32'(fifo_count), 32'd2);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("rm_valid", 32'(wif.word_valid), 32'd0);
        chk("rm_data", wif.word_data, 32'd0);
        chk("rm_count", 32'(fifo_count), 32'd0);
        chk("rm_ovf", 32'(overflow), 32'd0);
        chk("rm_pdrop", 32'(partial_drop), 32'd0);
        step(3);
        sys_rst_n = 1'b1;
        step(2);
        pop_log.delete();
        wif.word_ready = 1'b1;
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        step(3);
        chk("rm_nwords", 32'(pop_log.size()), 32'd1);
        chk("rm_word", logged(0), 32'hEFBE_ADDE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
